// File: rtl/uart_packet_tx.sv
// UART packet transmitter: fetches MSG_LEN words, splits them into frames
// (MS chunk first) and serializes with optional parity and error injection.
module uart_packet_tx #(
    parameter int FREQUENCY   = 50_000_000,
    parameter int SPEED       = 9600,
    parameter int DATA_BITS   = 8,
    parameter int WORD_W      = 16,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int MSG_LEN     = 5,
    parameter int ADDR_W      = 4,
    parameter int BASE_ADDR   = 0,
    parameter int FRAME_IDX_W = 8
) (
    input  logic                   CLK_i,
    input  logic                   reset_n,
    input  logic                   start_i,
    input  logic                   abort_i,
    output logic [ADDR_W-1:0]      mem_addr_o,
    input  logic [WORD_W-1:0]      mem_data_i,
    input  logic                   err_en_i,
    input  logic [FRAME_IDX_W-1:0] err_idx_i,
    input  logic [DATA_BITS-1:0]   err_mask_i,
    output logic                   tx_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [FRAME_IDX_W-1:0] frame_idx_o
);

    localparam int DIV      = FREQUENCY / SPEED;
    localparam int FPW      = WORD_W / DATA_BITS;
    localparam int STOP_LEN = STOP_BITS * DIV;
    localparam int CNT_W    = $clog2(STOP_LEN + 1);
    localparam int BIT_W    = $clog2(DATA_BITS);
    localparam int CH_W     = (FPW > 1) ? $clog2(FPW) : 1;
    localparam int WC_W     = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, START, DATA, PAR, STOP
    } state_t;

    state_t                 state, state_n;
    logic [CNT_W-1:0]       baud, baud_n;
    logic [BIT_W-1:0]       bit_cnt, bit_cnt_n;
    logic [CH_W-1:0]        chunk, chunk_n;
    logic [WC_W-1:0]        wc, wc_n;
    logic [WORD_W-1:0]      word_q, word_n;
    logic                   err_en_q, err_en_n;
    logic [FRAME_IDX_W-1:0] err_idx_q, err_idx_n;
    logic [DATA_BITS-1:0]   err_mask_q, err_mask_n;
    logic [ADDR_W-1:0]      addr_n;
    logic                   busy_n, done_n;
    logic [FRAME_IDX_W-1:0] fidx_n;

    logic [DATA_BITS-1:0]   clean;
    logic [DATA_BITS-1:0]   line_bits;
    logic                   hit;
    logic                   par_bit;
    logic                   baud_end;

    always_ff @(posedge CLK_i) begin
        if (!reset_n) begin
            state       <= IDLE;
            baud        <= '0;
            bit_cnt     <= '0;
            chunk       <= '0;
            wc          <= '0;
            word_q      <= '0;
            err_en_q    <= 1'b0;
            err_idx_q   <= '0;
            err_mask_q  <= '0;
            mem_addr_o  <= ADDR_W'(BASE_ADDR);
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            frame_idx_o <= '0;
        end else begin
            state       <= state_n;
            baud        <= baud_n;
            bit_cnt     <= bit_cnt_n;
            chunk       <= chunk_n;
            wc          <= wc_n;
            word_q      <= word_n;
            err_en_q    <= err_en_n;
            err_idx_q   <= err_idx_n;
            err_mask_q  <= err_mask_n;
            mem_addr_o  <= addr_n;
            busy_o      <= busy_n;
            done_o      <= done_n;
            frame_idx_o <= fidx_n;
        end
    end

    // Parity always covers the clean chunk so injected errors stay detectable
    assign clean     = word_q[int'(chunk) * DATA_BITS +: DATA_BITS];
    assign hit       = err_en_q && (frame_idx_o == err_idx_q);
    assign line_bits = clean ^ (hit ? err_mask_q : '0);
    assign par_bit   = (^clean) ^ (PARITY == 2);
    assign baud_end  = (baud == '0);

    always_comb begin
        state_n    = state;
        baud_n     = baud;
        bit_cnt_n  = bit_cnt;
        chunk_n    = chunk;
        wc_n       = wc;
        word_n     = word_q;
        err_en_n   = err_en_q;
        err_idx_n  = err_idx_q;
        err_mask_n = err_mask_q;
        addr_n     = mem_addr_o;
        busy_n     = busy_o;
        done_n     = 1'b0;
        fidx_n     = frame_idx_o;
        case (state)
            IDLE: begin
                if (start_i && !abort_i) begin
                    err_en_n   = err_en_i;
                    err_idx_n  = err_idx_i;
                    err_mask_n = err_mask_i;
                    addr_n     = ADDR_W'(BASE_ADDR);
                    wc_n       = '0;
                    busy_n     = 1'b1;
                    state_n    = FETCH;
                end
            end
            FETCH: state_n = LOAD;
            LOAD: begin
                word_n  = mem_data_i;
                chunk_n = CH_W'(FPW - 1);
                baud_n  = CNT_W'(DIV - 1);
                state_n = START;
            end
            START: begin
                if (baud_end) begin
                    baud_n    = CNT_W'(DIV - 1);
                    bit_cnt_n = '0;
                    state_n   = DATA;
                end else begin
                    baud_n = baud - CNT_W'(1);
                end
            end
            DATA: begin
                if (!baud_end) begin
                    baud_n = baud - CNT_W'(1);
                end else if (bit_cnt != BIT_W'(DATA_BITS - 1)) begin
                    baud_n    = CNT_W'(DIV - 1);
                    bit_cnt_n = bit_cnt + BIT_W'(1);
                end else if (PARITY != 0) begin
                    baud_n  = CNT_W'(DIV - 1);
                    state_n = PAR;
                end else begin
                    baud_n  = CNT_W'(STOP_LEN - 1);
                    state_n = STOP;
                end
            end
            PAR: begin
                if (baud_end) begin
                    baud_n  = CNT_W'(STOP_LEN - 1);
                    state_n = STOP;
                end else begin
                    baud_n = baud - CNT_W'(1);
                end
            end
            STOP: begin
                if (!baud_end) begin
                    baud_n = baud - CNT_W'(1);
                end else begin
                    fidx_n = frame_idx_o + FRAME_IDX_W'(1);
                    // Disarm after use so a wrapped index cannot hit twice
                    if (hit) err_en_n = 1'b0;
                    if (chunk != '0) begin
                        chunk_n = chunk - CH_W'(1);
                        baud_n  = CNT_W'(DIV - 1);
                        state_n = START;
                    end else if (wc != WC_W'(MSG_LEN - 1)) begin
                        addr_n  = mem_addr_o + ADDR_W'(1);
                        wc_n    = wc + WC_W'(1);
                        state_n = FETCH;
                    end else begin
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        fidx_n  = '0;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (abort_i && state != IDLE) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b0;
            fidx_n  = '0;
        end
    end

    always_comb begin
        tx_o = 1'b1;
        case (state)
            START:   tx_o = 1'b0;
            DATA:    tx_o = line_bits[bit_cnt];
            PAR:     tx_o = par_bit;
            default: tx_o = 1'b1;
        endcase
    end

endmodule
